smp_mixer: RTL

- Parametrised successor to the single-voice sample path: owns the sample-rate trigger and mixes CH_N generator voices into one stereo stream for sddac.
- Emits the smp_trig frame strobe and latches each voice's stereo sample as it arrives.
- When all voices are present or a timeout expires, applies a per-channel gain, accumulates sequentially, saturates, and emits one stereo sample with a ready pulse.

---
 rtl/smp_mixer_pkg.sv | 34 +++
 rtl/smp_trig_gen.sv | 38 +++
 rtl/smp_mixer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/smp_mixer_pkg.sv
// smp_mixer_pkg
//   Shared types and width helpers for the sample mixer and its trigger
//   generator.
//   - mix_state_t : mixer FSM state encoding
//   - clog2_min1  : index/counter width, never below one bit
//   - gain_unity  : unity gain code for a Q1.(GAIN_W-1) gain
//   - acc_width   : accumulator width that cannot overflow for CH_N voices
package smp_mixer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACC  = 3'd2,
    ST_SAT  = 3'd3,
    ST_OUT  = 3'd4
  } mix_state_t;

  localparam int SMP_W_DEFAULT = 18;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int gain_unity(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // One bit for the gain's extra headroom (gain < 2.0), one spare, plus
  // log2 of the number of voices summed.
  function automatic int acc_width(input int smp_w, input int ch_n);
    return smp_w + 2 + $clog2(ch_n);
  endfunction

endpackage

// File: rtl/smp_trig_gen.sv
// smp_trig_gen
//   Free-running frame counter that produces the sample-rate strobe.
//   The counter runs 0..TRIG_DIV-1 and wraps; the strobe is registered from
//   counter==1, so the first pulse appears after the second clock edge
//   following reset release and repeats every TRIG_DIV cycles.
// Ports
//   clk      : system clock
//   reset    : asynchronous, active-high reset
//   smp_trig : one-cycle frame strobe
module smp_trig_gen
  import smp_mixer_pkg::*;
#(
  parameter int TRIG_DIV = 2083
) (
  input  logic clk,
  input  logic reset,
  output logic smp_trig
);

  localparam int CNT_W = clog2_min1(TRIG_DIV);

  logic [CNT_W-1:0] trig_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_cnt <= '0;
      smp_trig <= 1'b0;
    end else begin
      if (trig_cnt == CNT_W'(TRIG_DIV - 1)) begin
        trig_cnt <= '0;
      end else begin
        trig_cnt <= trig_cnt + 1'b1;
      end
      smp_trig <= (trig_cnt == CNT_W'(1));
    end
  end

endmodule

// File: rtl/smp_mixer.sv
// smp_mixer
//   Mixes CH_N stereo generator voices into one stereo stream. Owns the frame
//   trigger, latches each voice as it arrives, and once all voices are in
//   (or WAIT_MAX cycles pass) scales each voice by its gain, sums them one
//   voice per cycle, saturates and presents the result with a ready pulse.
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   smp_trig          : one-cycle frame strobe to the generators
//   ch_rdy/ch_l/ch_r  : per-voice valid pulse and packed stereo samples
//   gain_we/ch/val    : gain register write port
//   flag_clr          : clears miss_flags and overrun
//   mix_rdy/mix_l/r   : one-cycle ready pulse and mixed stereo sample
//   miss_flags        : sticky, voice was absent when a timed-out mix began
//   overrun           : sticky, a frame strobe arrived while a mix was busy
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for smp_trig
// WAIT    | collecting voices; leaves when all valid or on timeout
// ACC     | one voice per cycle: scale by gain and add into L/R sums
// SAT     | clamp sums to the output range
// OUT     | publish mix_l/mix_r with a one-cycle mix_rdy
module smp_mixer
  import smp_mixer_pkg::*;
#(
  parameter int CH_N     = 4,
  parameter int SMP_W    = SMP_W_DEFAULT,
  parameter int GAIN_W   = 8,
  parameter int TRIG_DIV = 2083,
  parameter int WAIT_MAX = 2000
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          smp_trig,
  input  logic [CH_N-1:0]               ch_rdy,
  input  logic [CH_N*SMP_W-1:0]         ch_l,
  input  logic [CH_N*SMP_W-1:0]         ch_r,
  input  logic                          gain_we,
  input  logic [clog2_min1(CH_N)-1:0]   gain_ch,
  input  logic [GAIN_W-1:0]             gain_val,
  input  logic                          flag_clr,
  output logic                          mix_rdy,
  output logic signed [SMP_W-1:0]       mix_l,
  output logic signed [SMP_W-1:0]       mix_r,
  output logic [CH_N-1:0]               miss_flags,
  output logic                          overrun
);

  localparam int CH_W   = clog2_min1(CH_N);
  localparam int WT_W   = clog2_min1(WAIT_MAX);
  localparam int ACC_W  = acc_width(SMP_W, CH_N);
  localparam int PROD_W = SMP_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(gain_unity(GAIN_W));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SMP_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  mix_state_t state;

  logic signed [SMP_W-1:0]  hold_l [CH_N];
  logic signed [SMP_W-1:0]  hold_r [CH_N];
  logic [CH_N-1:0]          valid;
  logic [GAIN_W-1:0]        gain   [CH_N];

  logic [WT_W-1:0]          wait_tmr;
  logic [CH_W-1:0]          acc_k;
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic signed [SMP_W-1:0]  sat_l, sat_r;

  logic signed [SMP_W-1:0]  sel_l, sel_r;
  logic signed [GAIN_W:0]   gain_s;
  logic signed [PROD_W-1:0] prod_l, prod_r;
  logic signed [PROD_W-1:0] term_l, term_r;
  logic signed [SMP_W-1:0]  clamp_l, clamp_r;
  logic                     timeout;

  smp_trig_gen #(
    .TRIG_DIV (TRIG_DIV)
  ) u_trig (
    .clk      (clk),
    .reset    (reset),
    .smp_trig (smp_trig)
  );

  // Voice capture. A new sample arriving in the cycle its voice is consumed
  // keeps the valid bit set; the mix in progress already read the old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < CH_N; i++) begin
        hold_l[i] <= '0;
        hold_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_N; i++) begin
        if (ch_rdy[i]) begin
          hold_l[i] <= ch_l[i*SMP_W +: SMP_W];
          hold_r[i] <= ch_r[i*SMP_W +: SMP_W];
          valid[i]  <= 1'b1;
        end else if (state == ST_ACC && acc_k == CH_W'(i)) begin
          valid[i]  <= 1'b0;
        end
      end
    end
  end

  // Gain registers. Out-of-range channel indices are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH_N; i++) begin
        gain[i] <= GAIN_UNITY;
      end
    end else if (gain_we && (32'(gain_ch) < CH_N)) begin
      gain[gain_ch] <= gain_val;
    end
  end

  // Scaled contribution of the voice selected by acc_k. The arithmetic shift
  // rounds toward minus infinity.
  always_comb begin
    sel_l  = valid[acc_k] ? hold_l[acc_k] : '0;
    sel_r  = valid[acc_k] ? hold_r[acc_k] : '0;
    gain_s = $signed({1'b0, gain[acc_k]});
    prod_l = PROD_W'(sel_l) * PROD_W'(gain_s);
    prod_r = PROD_W'(sel_r) * PROD_W'(gain_s);
    term_l = prod_l >>> (GAIN_W - 1);
    term_r = prod_r >>> (GAIN_W - 1);
  end

  always_comb begin
    if (acc_l > SAT_MAX) begin
      clamp_l = SAT_MAX[SMP_W-1:0];
    end else if (acc_l < SAT_MIN) begin
      clamp_l = SAT_MIN[SMP_W-1:0];
    end else begin
      clamp_l = acc_l[SMP_W-1:0];
    end
    if (acc_r > SAT_MAX) begin
      clamp_r = SAT_MAX[SMP_W-1:0];
    end else if (acc_r < SAT_MIN) begin
      clamp_r = SAT_MIN[SMP_W-1:0];
    end else begin
      clamp_r = acc_r[SMP_W-1:0];
    end
  end

  // Wait timer counts down from WAIT_MAX-1; reaching zero ends WAIT on the
  // same cycle an up-count would reach WAIT_MAX-1.
  assign timeout = (state == ST_WAIT) && !(&valid) && (wait_tmr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_tmr   <= '0;
      acc_k      <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      sat_l      <= '0;
      sat_r      <= '0;
      mix_l      <= '0;
      mix_r      <= '0;
      mix_rdy    <= 1'b0;
      miss_flags <= '0;
      overrun    <= 1'b0;
    end else begin
      mix_rdy <= 1'b0;

      // Sticky flags: a set in the same cycle as flag_clr survives.
      miss_flags <= (flag_clr ? '0 : miss_flags) | (timeout ? ~valid : '0);
      overrun    <= (flag_clr ? 1'b0 : overrun) | (smp_trig && state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (smp_trig) begin
            wait_tmr <= WT_W'(WAIT_MAX - 1);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if ((&valid) || wait_tmr == '0) begin
            acc_k <= '0;
            acc_l <= '0;
            acc_r <= '0;
            state <= ST_ACC;
          end else begin
            wait_tmr <= wait_tmr - 1'b1;
          end
        end
        ST_ACC: begin
          acc_l <= acc_l + ACC_W'(term_l);
          acc_r <= acc_r + ACC_W'(term_r);
          if (acc_k == CH_W'(CH_N - 1)) begin
            acc_k <= '0;
            state <= ST_SAT;
          end else begin
            acc_k <= acc_k + 1'b1;
          end
        end
        ST_SAT: begin
          sat_l <= clamp_l;
          sat_r <= clamp_r;
          state <= ST_OUT;
        end
        ST_OUT: begin
          // Data and strobe change together so mix_l/mix_r only ever move
          // alongside a mix_rdy pulse.
          mix_l   <= sat_l;
          mix_r   <= sat_r;
          mix_rdy <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
